// File: rtl/proc_run_monitor.sv
// proc_run_monitor: checks processor stores against an expected table and latches a sticky pass/fail verdict
module proc_run_monitor #(
  parameter int WIDTH       = 32,
  parameter int NUM_EXP     = 1,
  parameter int PC_LIMIT    = 6,
  parameter int MAX_CYCLES  = 64,
  parameter int ALLOW_UNEXP = 0,
  parameter int CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run_en,
  input  logic [WIDTH-1:0]         pc,
  input  logic                     mem_write,
  input  logic [WIDTH-1:0]         data_adr,
  input  logic [WIDTH-1:0]         write_data,
  input  logic [NUM_EXP*WIDTH-1:0] exp_adr,
  input  logic [NUM_EXP*WIDTH-1:0] exp_data,
  input  logic [NUM_EXP-1:0]       exp_valid,
  output logic                     done,
  output logic                     pass,
  output logic [2:0]               fail_code,
  output logic [WIDTH-1:0]         fail_pc,
  output logic [NUM_EXP-1:0]       match_mask,
  output logic [CNT_W-1:0]         cycle_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic               pass_q, pass_d;
  logic [2:0]         code_q, code_d, code_n;
  logic [WIDTH-1:0]   fpc_q, fpc_d;
  logic [NUM_EXP-1:0] mask_q, mask_d, mask_n, hit, sel;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_n;
  logic               go, unexp, pc_end, to, all_ok, term;
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_EXP; i++)
      hit[i] = exp_valid[i] && !mask_q[i] && data_adr == exp_adr[i*WIDTH +: WIDTH]
               && write_data == exp_data[i*WIDTH +: WIDTH];
  end
  // isolate the lowest set bit so duplicate entries are consumed one store at a time
  assign sel    = hit & (~hit + NUM_EXP'(1));
  assign unexp  = mem_write && hit == '0 && ALLOW_UNEXP == 0;
  assign mask_n = mem_write ? mask_q | sel : mask_q;
  assign cnt_n  = cnt_q + CNT_W'(1);
  assign all_ok = &(mask_n | ~exp_valid);
  assign pc_end = (pc >> 2) >= WIDTH'(PC_LIMIT);
  assign to     = cnt_n == CNT_W'(MAX_CYCLES);
  assign term   = unexp || pc_end || to;
  assign code_n = unexp ? 3'd1 : pc_end ? (all_ok ? 3'd0 : 3'd2) : to ? 3'd3 : 3'd0;
  assign go     = state_q != DONE && run_en;
  always_comb begin
    state_d = !go ? state_q : term ? DONE : RUN;
    cnt_d   = go ? cnt_n : cnt_q;
    mask_d  = go ? mask_n : mask_q;
    pass_d  = go && term ? code_n == 3'd0 : pass_q;
    code_d  = go && term ? code_n : code_q;
    fpc_d   = go && term ? pc : fpc_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
      code_q  <= 3'd0;
      fpc_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
      fpc_q   <= fpc_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end
  assign done        = state_q == DONE;
  assign pass        = pass_q;
  assign fail_code   = code_q;
  assign fail_pc     = fpc_q;
  assign match_mask  = mask_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_proc_run_monitor.sv
// tb_proc_run_monitor: directed checks of four monitor configurations sharing one stimulus bus
module tb_proc_run_monitor;
  logic clk = 1'b0, reset = 1'b0, run_en = 1'b0, mem_write = 1'b0;
  logic [31:0] pc = '0, data_adr = '0, write_data = '0;
  logic [31:0] ea1 = 32'h64, ed1 = 32'd7;
  logic [63:0] ea2 = {32'h64, 32'h64}, ed2 = {32'd7, 32'd7};
  logic v1 = 1'b1;
  logic [1:0] v2 = 2'b11;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  logic d0, p0, d1, p1, d2, p2, d3, p3;
  logic [2:0] c0, c1, c2, c3;
  logic [31:0] f0, f1, f2, f3;
  logic m0, m1, m2;
  logic [1:0] m3;
  logic [6:0] n0, n1, n2, n3;
  proc_run_monitor u0 (.clk(clk), .reset(reset), .run_en(run_en), .pc(pc), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .exp_adr(ea1), .exp_data(ed1), .exp_valid(v1),
    .done(d0), .pass(p0), .fail_code(c0), .fail_pc(f0), .match_mask(m0), .cycle_count(n0));
  proc_run_monitor #(.ALLOW_UNEXP(1)) u1 (.clk(clk), .reset(reset), .run_en(run_en), .pc(pc),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data), .exp_adr(ea1), .exp_data(ed1),
    .exp_valid(v1), .done(d1), .pass(p1), .fail_code(c1), .fail_pc(f1), .match_mask(m1), .cycle_count(n1));
  proc_run_monitor #(.PC_LIMIT(100)) u2 (.clk(clk), .reset(reset), .run_en(run_en), .pc(pc),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data), .exp_adr(ea1), .exp_data(ed1),
    .exp_valid(v1), .done(d2), .pass(p2), .fail_code(c2), .fail_pc(f2), .match_mask(m2), .cycle_count(n2));
  proc_run_monitor #(.NUM_EXP(2)) u3 (.clk(clk), .reset(reset), .run_en(run_en), .pc(pc),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data), .exp_adr(ea2), .exp_data(ed2),
    .exp_valid(v2), .done(d3), .pass(p3), .fail_code(c3), .fail_pc(f3), .match_mask(m3), .cycle_count(n3));

  task automatic cyc(input logic [31:0] p, input logic mw, input logic [31:0] a, input logic [31:0] d);
    pc = p; mem_write = mw; data_adr = a; write_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; run_en = 1'b0;
    cyc(0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({d0, p0, c0, f0, m0, n0} !== '0) begin failures++; $display("FAIL reset_zero got=%0h exp=0", {d0, p0, c0, f0, m0, n0}); end
    cyc(4, 0, 0, 0);
    checks++; if ({d0, n0} !== '0) begin failures++; $display("FAIL idle_hold got=%0h exp=0", {d0, n0}); end
  endtask

  task automatic test_pass();
    do_reset(); run_en = 1'b1;
    for (int k = 1; k <= 5; k++) cyc(k * 4, k == 3, 32'h64, 7);
    checks++; if (d0 !== 1'b0 || m0 !== 1'b1 || n0 !== 7'd5) begin failures++; $display("FAIL pass_pre got=%b/%b/%0d exp=0/1/5", d0, m0, n0); end
    cyc(32'h18, 0, 0, 0);
    checks++; if (d0 !== 1'b1 || p0 !== 1'b1 || c0 !== 3'd0) begin failures++; $display("FAIL pass_verdict got=%b/%b/%0d exp=1/1/0", d0, p0, c0); end
    checks++; if (m0 !== 1'b1 || n0 !== 7'd6 || f0 !== 32'h18) begin failures++; $display("FAIL pass_info got=%b/%0d/%0h exp=1/6/18", m0, n0, f0); end
    cyc(32'h1c, 1, 32'h60, 1);
    checks++; if (d0 !== 1'b1 || p0 !== 1'b1 || n0 !== 7'd6 || c0 !== 3'd0) begin failures++; $display("FAIL pass_sticky got=%b/%b/%0d/%0d exp=1/1/6/0", d0, p0, n0, c0); end
  endtask

  task automatic test_unexpected();
    do_reset(); run_en = 1'b1;
    cyc(4, 0, 0, 0);
    cyc(8, 1, 32'h60, 7);
    checks++; if (d0 !== 1'b1 || p0 !== 1'b0 || c0 !== 3'd1) begin failures++; $display("FAIL unexp_verdict got=%b/%b/%0d exp=1/0/1", d0, p0, c0); end
    checks++; if (f0 !== 32'h8 || n0 !== 7'd2 || m0 !== 1'b0) begin failures++; $display("FAIL unexp_info got=%0h/%0d/%b exp=8/2/0", f0, n0, m0); end
    checks++; if (d1 !== 1'b0 || n1 !== 7'd2) begin failures++; $display("FAIL allow_run got=%b/%0d exp=0/2", d1, n1); end
    cyc(12, 0, 0, 0);
    checks++; if (n0 !== 7'd2 || n1 !== 7'd3 || d1 !== 1'b0) begin failures++; $display("FAIL allow_cont got=%0d/%0d/%b exp=2/3/0", n0, n1, d1); end
  endtask

  task automatic test_missing();
    do_reset(); run_en = 1'b1;
    for (int k = 1; k <= 6; k++) cyc(k * 4, 0, 0, 0);
    checks++; if (d0 !== 1'b1 || p0 !== 1'b0 || c0 !== 3'd2) begin failures++; $display("FAIL missing_verdict got=%b/%b/%0d exp=1/0/2", d0, p0, c0); end
    checks++; if (m0 !== 1'b0 || n0 !== 7'd6 || f0 !== 32'h18) begin failures++; $display("FAIL missing_info got=%b/%0d/%0h exp=0/6/18", m0, n0, f0); end
  endtask

  task automatic test_timeout();
    do_reset(); run_en = 1'b1;
    for (int k = 1; k <= 63; k++) cyc(0, 0, 0, 0);
    checks++; if (d2 !== 1'b0 || n2 !== 7'd63) begin failures++; $display("FAIL timeout_pre got=%b/%0d exp=0/63", d2, n2); end
    cyc(0, 0, 0, 0);
    checks++; if (d2 !== 1'b1 || p2 !== 1'b0 || c2 !== 3'd3 || n2 !== 7'd64) begin failures++; $display("FAIL timeout got=%b/%b/%0d/%0d exp=1/0/3/64", d2, p2, c2, n2); end
    cyc(0, 0, 0, 0);
    checks++; if (n2 !== 7'd64 || c2 !== 3'd3) begin failures++; $display("FAIL timeout_hold got=%0d/%0d exp=64/3", n2, c2); end
  endtask

  task automatic test_back_to_back();
    do_reset(); run_en = 1'b1;
    cyc(4, 1, 32'h64, 7);
    checks++; if (m3 !== 2'b01 || d3 !== 1'b0) begin failures++; $display("FAIL dup_first got=%b/%b exp=01/0", m3, d3); end
    cyc(8, 1, 32'h64, 7);
    checks++; if (m3 !== 2'b11 || d3 !== 1'b0) begin failures++; $display("FAIL dup_second got=%b/%b exp=11/0", m3, d3); end
    cyc(12, 1, 32'h64, 7);
    checks++; if (d3 !== 1'b1 || c3 !== 3'd1 || p3 !== 1'b0 || n3 !== 7'd3) begin failures++; $display("FAIL dup_third got=%b/%0d/%b/%0d exp=1/1/0/3", d3, c3, p3, n3); end
    do_reset(); run_en = 1'b1;
    cyc(4, 1, 32'h64, 7);
    cyc(32'h18, 1, 32'h64, 7);
    checks++; if (d3 !== 1'b1 || p3 !== 1'b1 || c3 !== 3'd0 || m3 !== 2'b11 || n3 !== 7'd2) begin failures++; $display("FAIL same_edge got=%b/%b/%0d/%b/%0d exp=1/1/0/11/2", d3, p3, c3, m3, n3); end
  endtask

  task automatic test_rerun();
    do_reset(); run_en = 1'b1;
    for (int k = 1; k <= 4; k++) cyc(0, k == 2, 32'h64, 7);
    checks++; if (n0 !== 7'd4 || m0 !== 1'b1) begin failures++; $display("FAIL rerun_pre got=%0d/%b exp=4/1", n0, m0); end
    reset = 1'b0;
    cyc(32'h18, 0, 0, 0);
    checks++; if ({d0, p0, c0, f0, m0, n0} !== '0) begin failures++; $display("FAIL midrun_reset got=%0h exp=0", {d0, p0, c0, f0, m0, n0}); end
    reset = 1'b1;
    cyc(4, 0, 0, 0);
    checks++; if (n0 !== 7'd1 || d0 !== 1'b0) begin failures++; $display("FAIL rerun_start got=%0d/%b exp=1/0", n0, d0); end
    run_en = 1'b0;
    for (int k = 0; k < 3; k++) cyc(32'h18, 1, 32'h64, 7);
    checks++; if (n0 !== 7'd1 || d0 !== 1'b0 || m0 !== 1'b0) begin failures++; $display("FAIL pause got=%0d/%b/%b exp=1/0/0", n0, d0, m0); end
    run_en = 1'b1;
    cyc(8, 0, 0, 0);
    checks++; if (n0 !== 7'd2 || d0 !== 1'b0) begin failures++; $display("FAIL resume got=%0d/%b exp=2/0", n0, d0); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_unexpected();
    test_missing();
    test_timeout();
    test_back_to_back();
    test_rerun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_run_monitor.md
# proc_run_monitor

Synthesizable run monitor for the single-cycle processor tops (e.g. bl_proc_top). It sits beside the processor and observes PC and the data-memory write port. It checks stores against a parametrised table of expected (address, data) pairs and terminates the run on a PC bound, an unexpected store, or a cycle timeout. It reports a sticky pass/fail verdict usable from a bench or an FPGA LED/debug port.

## Interface
Parameters:
- WIDTH, 32, datapath/address width
- NUM_EXP, 1, number of expected-store entries (1..8)
- PC_LIMIT, 6, run ends when (pc >> 2) >= PC_LIMIT (word index)
- MAX_CYCLES, 64, run-cycle timeout (>= 1)
- ALLOW_UNEXP, 0, 1 = unmatched stores are ignored instead of failing
- CNT_W, $clog2(MAX_CYCLES+1), cycle counter width

Ports:
- clk  in  1  clock; all sampling on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- run_en  in  1  start/continue monitoring; low in RUN freezes checks and counter
- pc  in  WIDTH  processor PC
- mem_write  in  1  processor store strobe
- data_adr  in  WIDTH  store address
- write_data  in  WIDTH  store data
- exp_adr  in  NUM_EXP*WIDTH  expected addresses, entry i at [i*WIDTH +: WIDTH]
- exp_data  in  NUM_EXP*WIDTH  expected data, same packing
- exp_valid  in  NUM_EXP  entry enable; disabled entries never match, count as already satisfied
- done  out  1  verdict available (sticky)
- pass  out  1  run passed (valid when done)
- fail_code  out  3  0 none, 1 unexpected store, 2 missing store, 3 timeout
- fail_pc  out  WIDTH  pc sampled on terminating cycle
- match_mask  out  NUM_EXP  entries matched so far
- cycle_count  out  CNT_W  RUN cycles sampled

## Operation
- States: IDLE, RUN, DONE. reset low → IDLE, all outputs 0.
- IDLE → RUN on the first edge with run_en=1. That same edge is the first checked sample (cycle_count becomes 1).
- In RUN, each edge with run_en=1 samples the inputs, increments cycle_count, and evaluates the steps in order:
  1. Store: if mem_write=1, find the lowest index i with exp_valid[i]=1, match_mask[i]=0, data_adr==exp_adr[i] and write_data==exp_data[i]; set match_mask[i]. No such i → unexpected store. A repeat of an already-matched pair is unexpected. If ALLOW_UNEXP=0, unexpected store → DONE with fail_code=1.
  2. PC bound: if not already failed and (pc>>2) >= PC_LIMIT → DONE. pass=1 if every valid entry is matched, including a match made this edge; otherwise fail_code=2.
  3. Timeout: if not terminated and the new cycle_count == MAX_CYCLES → DONE, fail_code=3.
- Priority on the same edge: unexpected store > PC bound > timeout.
- DONE is sticky. Only reset low leaves it, and run_en is ignored there. pass and fail_code are mutually exclusive; fail_code=0 iff pass=1.
- exp_* inputs must be stable from IDLE exit to DONE. Changes mid-run are undefined.
- cycle_count never wraps: it stops at its terminating value (at most MAX_CYCLES).

## Timing
- Outputs are registered. done/pass/fail_code/fail_pc update at the edge that samples the terminating condition and are visible in the following cycle. Verdict latency is 0 cycles after the sampling edge.
- match_mask bit sets at the matching store's edge.
- reset low on any edge, including mid-RUN or in DONE, forces IDLE and zeros all outputs at that edge. It wins over every other event.
- run_en=0 in RUN: no sampling, counter holds, stores ignored.

## Test plan
- Program fragment: exp entry 0 = (0x64, 7). Store (0x64, 7) at cycle 3, pc reaches 0x18 at cycle 6 → done=1, pass=1, match_mask=1, cycle_count=6, fail_pc=0x18.
- Store (0x60, 7) at cycle 2, ALLOW_UNEXP=0 → done at that edge, fail_code=1, fail_pc = that pc, cycle_count=2. Same stimulus with ALLOW_UNEXP=1 → run continues.
- No store, pc reaches 0x18 → fail_code=2, pass=0, match_mask=0.
- PC_LIMIT=100, MAX_CYCLES=64, pc stuck at 0 → done at cycle_count=64, fail_code=3.
- NUM_EXP=2 with identical entries (0x64, 7): two such stores → mask 01 then 11; a third → fail_code=1. Matching store on the same edge pc hits the limit → pass=1.
- reset low mid-RUN at cycle 4, then rerun → all outputs 0 after reset, new run restarts cycle_count at 1; run_en toggled low 3 cycles → cycle_count excludes them.
